// File: rtl/pe_link_fifo.sv
// Show-ahead link FIFO feeding a mesh PE input port; head word is exposed
// combinationally and out_start doubles as the PE ap_start / pop strobe.
module pe_link_fifo #(
  parameter int unsigned DATA_WIDTH = 130,
  parameter int unsigned ADDR_BITS  = 3,
  parameter int unsigned AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_start,
  output logic [ADDR_BITS:0]    count,
  output logic                  almost_full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AF_COUNT   = (ADDR_BITS + 1)'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic                  push;
  logic                  pop;

  assign in_ready    = (count != FULL_COUNT);
  assign out_start   = (count != '0) && !hold;
  assign push        = in_valid && in_ready;
  assign pop         = out_start;
  assign almost_full = (count >= AF_COUNT);
  assign empty       = (count == '0);

  // Empty FIFO shows zeros rather than whatever the stale slot holds.
  assign out_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_link_fifo.sv
// Self-checking bench for pe_link_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based occupancy model.
module tb_pe_link_fifo;

  localparam int DW = 130;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic [DW-1:0] out_data;
  logic          out_start;
  logic [3:0]    count;
  logic          almost_full;
  logic          empty;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] q[$];

  pe_link_fifo #(.DATA_WIDTH(130), .ADDR_BITS(3), .AF_LEVEL(6)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .hold(hold), .out_data(out_data),
    .out_start(out_start), .count(count), .almost_full(almost_full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] m_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // One clock edge; the model applies the FIFO rules to the inputs held across it.
  task automatic tick();
    logic          do_push, do_pop;
    logic [DW-1:0] d;
    do_push = in_valid && (q.size() < 8);
    do_pop  = (q.size() > 0) && !hold;
    d       = in_data;
    @(posedge clk);
    if (!reset) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; hold = 1'b0; in_data = 130'h5;
    tick(); tick();
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_start !== 1'b0) begin fails++; $display("FAIL reset_out_start: got %b expected 0", out_start); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
    reset = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    hold = 1'b0; in_valid = 1'b1; in_data = 130'h1_DEAD_BEEF;
    #1;
    checks++; if (out_start !== 1'b0) begin fails++; $display("FAIL single_no_bypass: got %b expected 0", out_start); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b expected 1", out_start); end
    checks++; if (out_data !== 130'h1_DEAD_BEEF) begin fails++; $display("FAIL single_data: got %0h expected 1deadbeef", out_data); end
    tick();
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL single_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty: got %b expected 1", empty); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL single_empty_data: got %0h expected 0", out_data); end
  endtask

  task automatic test_fill();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
      #1;
      checks++; if (count !== 4'(i + 1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 6)) begin fails++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 6)); end
      checks++; if (out_start !== 1'b0) begin fails++; $display("FAIL fill_hold_start[%0d]: got %b expected 0", i, out_start); end
    end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    in_data = DW'(8);
    tick(); tick();
    #1;
    checks++; if (count !== 4'd8) begin fails++; $display("FAIL fill_overflow_count: got %0d expected 8", count); end
    checks++; if (out_data !== DW'(0)) begin fails++; $display("FAIL fill_head: got %0h expected 0", out_data); end
  endtask

  task automatic test_drain_wrap();
    int nxt = 8;
    int exp_idx = 0;
    bit freed_late = 1'b0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 60 && exp_idx < 16; cyc++) begin
      in_valid = (nxt <= 15); in_data = DW'(nxt);
      #1;
      if (cyc == 0) begin
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL drain_same_cycle_ready: got %b expected 0", in_ready); end
      end
      if (cyc == 1) freed_late = in_ready;
      checks++; if (out_start !== (q.size() > 0)) begin fails++; $display("FAIL drain_start[%0d]: got %b expected %b", cyc, out_start, (q.size() > 0)); end
      if (out_start) begin
        checks++; if (out_data !== DW'(exp_idx)) begin fails++; $display("FAIL drain_data[%0d]: got %0h expected %0h", cyc, out_data, exp_idx); end
        exp_idx++;
      end
      if (in_valid && q.size() < 8) nxt++;
      tick();
    end
    checks++; if (exp_idx != 16) begin fails++; $display("FAIL drain_timeout: got %0d words expected 16", exp_idx); end
    checks++; if (freed_late !== 1'b1) begin fails++; $display("FAIL drain_ready_after_pop: got %b expected 1", freed_late); end
    in_valid = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_concurrent();
    hold = 1'b1; in_valid = 1'b1; in_data = 130'h9;
    tick();
    hold = 1'b0; in_data = 130'hA;
    #1;
    checks++; if (out_data !== 130'h9) begin fails++; $display("FAIL conc_head: got %0h expected 9", out_data); end
    checks++; if (out_start !== 1'b1) begin fails++; $display("FAIL conc_start: got %b expected 1", out_start); end
    tick();
    in_valid = 1'b0; hold = 1'b1;
    #1;
    checks++; if (count !== 4'd1) begin fails++; $display("FAIL conc_count: got %0d expected 1", count); end
    checks++; if (out_data !== 130'hA) begin fails++; $display("FAIL conc_new_head: got %0h expected a", out_data); end
    hold = 1'b0;
    tick();
  endtask

  task automatic test_midstream_reset();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(32'h100 + i);
      tick();
    end
    #1;
    checks++; if (count !== 4'd5) begin fails++; $display("FAIL mid_prefill: got %0d expected 5", count); end
    reset = 1'b0; hold = 1'b0; in_data = 130'h55;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL mid_count: got %0d expected 0", count); end
    checks++; if (out_start !== 1'b0) begin fails++; $display("FAIL mid_start: got %b expected 0", out_start); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL mid_data: got %0h expected 0", out_data); end
    in_valid = 1'b1; in_data = 130'h77;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_data !== 130'h77) begin fails++; $display("FAIL mid_first_word: got %0h expected 77", out_data); end
    checks++; if (out_start !== 1'b1) begin fails++; $display("FAIL mid_first_start: got %b expected 1", out_start); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] got_flags, exp_flags;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset    = ($urandom_range(0, 59) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      hold     = ($urandom_range(0, 2) == 0);
      in_data  = rand_word();
      #1;
      got_flags = {count, in_ready, out_start, almost_full};
      exp_flags = {4'(q.size()), q.size() != 8, (q.size() != 0) && !hold, q.size() >= 6};
      checks++; if (got_flags !== exp_flags) begin fails++; $display("FAIL rand_flags[%0d]: got %b expected %b", cyc, got_flags, exp_flags); end
      checks++; if (empty !== (q.size() == 0)) begin fails++; $display("FAIL rand_empty[%0d]: got %b expected %b", cyc, empty, (q.size() == 0)); end
      checks++; if (out_data !== m_head()) begin fails++; $display("FAIL rand_data[%0d]: got %0h expected %0h", cyc, out_data, m_head()); end
      tick();
    end
    reset = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; hold = 1'b0; in_data = '0;
    #2;
    test_reset();
    test_single();
    test_fill();
    test_drain_wrap();
    test_concurrent();
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
